// File: rtl/serial_word_deserializer_if.sv
// Word-stream bundle for the serial word deserializer.
// The serial side (bit_en/bit_in/frame_start) and the word handshake side
// (word_valid/word_ready/word_out) travel together. The master modport is the
// deserializer's view. The slave modport is the view of the link driver and
// the consumer.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             bit_en;
  logic             bit_in;
  logic             frame_start;
  logic             word_valid;
  logic             word_ready;
  logic [WIDTH-1:0] word_out;

  modport master (
    input  bit_en,
    input  bit_in,
    input  frame_start,
    input  word_ready,
    output word_valid,
    output word_out
  );

  modport slave (
    output bit_en,
    output bit_in,
    output frame_start,
    output word_ready,
    input  word_valid,
    input  word_out
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// Serial-in / parallel-out receiver.
// Shifts qualified serial bits into a WIDTH-bit word. A completed word goes
// into a single-entry holding register, which is offered on a valid/ready
// port. When the holding register is still occupied and not being drained, a
// new completed word is dropped and the sticky overrun flag is raised.
module serial_word_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  serial_word_deserializer_if.master bus,
  output logic [$clog2(WIDTH)-1:0] bit_count_o,
  output logic                     overrun_o
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] restart;
  logic             complete;
  logic             xfer;

  // Next state: bit capture, realignment, word completion and holding-register
  // arbitration, with clear overriding everything else.
  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    word_d   = word_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    complete = 1'b0;
    xfer     = valid_q & bus.word_ready;

    shifted = MSB_FIRST ? {sh_q[WIDTH-2:0], bus.bit_in}
                        : {bus.bit_in, sh_q[WIDTH-1:1]};
    restart = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.bit_in}
                        : {bus.bit_in, {(WIDTH-1){1'b0}}};

    if (bus.bit_en) begin
      if (bus.frame_start) begin
        // Realign: the partial word is abandoned and this bit becomes bit 0.
        sh_d  = restart;
        cnt_d = CW'(1);
      end else begin
        sh_d = shifted;
        if (cnt_q == CW'(WIDTH - 1)) begin
          complete = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    // A completed word can be loaded if the slot is empty or is being drained
    // on this edge. Otherwise the old word is kept and the new one is lost.
    if (complete) begin
      if (!valid_q || xfer) begin
        word_d  = sh_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    if (clear_i) begin
      sh_d    = '0;
      cnt_d   = '0;
      word_d  = '0;
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  // State registers: async reset drops any partial word and any pending output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.word_valid = valid_q;
  assign bus.word_out   = word_q;
  assign bit_count_o    = cnt_q;
  assign overrun_o      = ovr_q;

endmodule

// File: tb/tb_serial_word_deserializer.sv
// Scoreboard bench for serial_word_deserializer.
// Two instances, one MSB-first and one LSB-first, receive the same serial
// stream and handshake. A reference model collects the received bits as a list.
// It forms each completed word arithmetically in both bit orders and queues the
// words that the holding slot is expected to present. A negedge monitor checks
// the outputs against the model and pops the queue on each transfer.
module tb_serial_word_deserializer;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic [2:0] cntM, cntL;
  logic ovrM, ovrL;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit   mBits[$];
  bit   mValid = 1'b0;
  bit   mOvr = 1'b0;
  exp_t expQ[$];

  serial_word_deserializer_if #(.WIDTH(W)) busM();
  serial_word_deserializer_if #(.WIDTH(W)) busL();

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dutMsb (
    .clk(clk), .reset(reset), .clear_i(clear), .bus(busM.master),
    .bit_count_o(cntM), .overrun_o(ovrM)
  );

  serial_word_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dutLsb (
    .clk(clk), .reset(reset), .clear_i(clear), .bus(busL.master),
    .bit_count_o(cntL), .overrun_o(ovrL)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Time limit so the run can never hang
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation still running, limit reached");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBits.delete();
    mValid = 1'b0;
    mOvr = 1'b0;
    expQ.delete();
  endtask

  // Reference model step for one rising edge with the given inputs.
  task automatic modelEdge(input bit en, input bit b, input bit fs, input bit rdy, input bit clr);
    bit xfer;
    bit done;
    exp_t e;
    xfer = mValid && rdy;
    done = 1'b0;
    e.msb = '0;
    e.lsb = '0;
    if (clr) begin
      modelReset();
    end else begin
      if (en) begin
        if (fs) begin
          mBits.delete();
          mBits.push_back(b);
        end else begin
          mBits.push_back(b);
          if (mBits.size() == W) begin
            done = 1'b1;
            for (int i = 0; i < W; i++) begin
              e.msb = e.msb * 2 + W'(mBits[i]);
              e.lsb = e.lsb + (W'(mBits[i]) << i);
            end
            mBits.delete();
          end
        end
      end
      if (done) begin
        if (!mValid || xfer) begin
          expQ.push_back(e);
          mValid = 1'b1;
        end else begin
          mOvr = 1'b1;
        end
      end else if (xfer) begin
        mValid = 1'b0;
      end
    end
  endtask

  // Drive one cycle of inputs (shortly after a rising edge), clock it, update the model.
  task automatic applyStimulus(input bit en, input bit b, input bit fs, input bit rdy, input bit clr);
    busM.bit_en = en;      busL.bit_en = en;
    busM.bit_in = b;       busL.bit_in = b;
    busM.frame_start = fs; busL.frame_start = fs;
    busM.word_ready = rdy; busL.word_ready = rdy;
    clear = clr;
    @(posedge clk);
    modelEdge(en, b, fs, rdy, clr);
    #1;
  endtask

  // Send a word as a stream, first bit = w[W-1]; the last bit may use a different ready.
  task automatic sendWord(input logic [W-1:0] w, input bit realign, input bit rdy, input bit lastRdy);
    for (int i = 0; i < W; i++)
      applyStimulus(1'b1, w[W-1-i], realign && (i == 0), (i == W-1) ? lastRdy : rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset pulse in mid-cycle; outputs must drop before any clock edge.
  task automatic pulseReset();
    busM.bit_en = 1'b0; busL.bit_en = 1'b0;
    #2;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("rst validM", 32'(busM.word_valid), 32'd0);
    checkOutput("rst validL", 32'(busL.word_valid), 32'd0);
    checkOutput("rst wordM", 32'(busM.word_out), 32'd0);
    checkOutput("rst wordL", 32'(busL.word_out), 32'd0);
    checkOutput("rst countM", 32'(cntM), 32'd0);
    checkOutput("rst overrunM", 32'(ovrM), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares status every cycle, checks the held word and pops on transfer.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("valid M", 32'(busM.word_valid), 32'(mValid));
      checkOutput("valid L", 32'(busL.word_valid), 32'(mValid));
      checkOutput("bit_count M", 32'(cntM), 32'(mBits.size()));
      checkOutput("bit_count L", 32'(cntL), 32'(mBits.size()));
      checkOutput("overrun M", 32'(ovrM), 32'(mOvr));
      checkOutput("overrun L", 32'(ovrL), 32'(mOvr));
      if (busM.word_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard empty", 32'd1, 32'd0);
        end else begin
          checkOutput("word_out M", 32'(busM.word_out), 32'(expQ[0].msb));
          checkOutput("word_out L", 32'(busL.word_out), 32'(expQ[0].lsb));
          if (busM.word_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    busM.bit_en = 1'b0; busL.bit_en = 1'b0;
    busM.bit_in = 1'b0; busL.bit_in = 1'b0;
    busM.frame_start = 1'b0; busL.frame_start = 1'b0;
    busM.word_ready = 1'b0; busL.word_ready = 1'b0;

    // Power-on reset
    #3;
    checkOutput("por valid", 32'(busM.word_valid), 32'd0);
    checkOutput("por count", 32'(cntM), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A5 with ready high, then an 0x01-style LSB order check
    sendWord(8'hA5, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    sendWord(8'h80, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Overrun: 3C held, C3 dropped, single drain, overrun sticky until clear
    sendWord(8'h3C, 1'b0, 1'b0, 1'b0);
    sendWord(8'hC3, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(1, 1'b1);
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b0);

    // Back-to-back: 11 held, drained on the edge that completes 22
    sendWord(8'h11, 1'b0, 1'b0, 1'b0);
    sendWord(8'h22, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Realign after 5 bits, then F0
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    sendWord(8'hF0, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);

    // frame_start without bit_en is ignored
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b1);

    // Reset mid-word and with a pending word
    pulseReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'($urandom), 1'b0, 1'b1, 1'b0);
    pulseReset();
    sendWord(8'h5A, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    pulseReset();
    sendWord(8'h96, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Randomized traffic with varying ready pressure
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 200; i++) begin
        applyStimulus(($urandom % 4) != 0, 1'($urandom), ($urandom % 20) == 0,
                      ($urandom % (r + 2)) != 0, ($urandom % 150) == 0);
      end
      pulseReset();
    end
    idle(3, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
